mul_csa_reduce_stage: RTL and testbench

MUL_CSA_REDUCE_STAGE -- requirements
Module: mul_csa_reduce_stage

---
 rtl/mul_pkg.sv | 20 ++
 rtl/csa4_2_row.sv | 24 ++
 rtl/mul_csa_reduce_stage.sv | 125 ++++++++++++
 tb/tb_mul_csa_reduce_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared constants, occupancy encoding and bus-slicing helper for the
// multiplier partial-product reduction blocks.
package mul_pkg;

   localparam int MUL_W       = 128;
   localparam int MUL_N_PAIRS = 8;
   localparam int MUL_TAG_W   = 3;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   // Low bit of row idx in a packed bus of w-bit rows.
   function automatic int row_lo(input int idx, input int w);
      return idx * w;
   endfunction

endpackage

// File: rtl/csa4_2_row.sv
// One W-bit 4:2 compressor built from two cascaded 3:2 carry-save rows.
module csa4_2_row #(
   parameter int W = 128
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] c_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] sum_o,
   output logic [W-1:0] carry_o
);

   logic [W-1:0] s1, c1, maj1, maj2;

   assign s1   = a_i ^ b_i ^ c_i;
   assign maj1 = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
   // Shifting the majority left drops the carry out of bit W-1 and zeroes bit 0.
   assign c1   = {maj1[W-2:0], 1'b0};

   assign sum_o   = s1 ^ c1 ^ d_i;
   assign maj2    = (s1 & c1) | (s1 & d_i) | (c1 & d_i);
   assign carry_o = {maj2[W-2:0], 1'b0};

endmodule

// File: rtl/mul_csa_reduce_stage.sv
// Pipelined 4:2 carry-save reduction stage with a two-entry (main/skid)
// elastic buffer; halves the number of sum/carry row pairs per beat.
module mul_csa_reduce_stage
   import mul_pkg::*;
#(
   parameter int W       = MUL_W,
   parameter int N_PAIRS = MUL_N_PAIRS,
   parameter int TAG_W   = MUL_TAG_W
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic                       InValid,
   output logic                       InReady,
   input  logic [N_PAIRS*W-1:0]       InSum,
   input  logic [N_PAIRS*W-1:0]       InCarry,
   input  logic [TAG_W-1:0]           InTag,
   input  logic                       Flush,
   output logic                       OutValid,
   input  logic                       OutReady,
   output logic [(N_PAIRS/2)*W-1:0]   OutSum,
   output logic [(N_PAIRS/2)*W-1:0]   OutCarry,
   output logic [TAG_W-1:0]           OutTag,
   output logic                       Busy
);

   localparam int NK = N_PAIRS / 2;
   localparam int OW = NK * W;

   logic [OW-1:0] red_sum, red_carry;

   for (genvar k = 0; k < NK; k++) begin : g_csa
      csa4_2_row #(.W(W)) u_csa (
         .a_i    (InSum  [row_lo(2*k,   W) +: W]),
         .b_i    (InSum  [row_lo(2*k+1, W) +: W]),
         .c_i    (InCarry[row_lo(2*k,   W) +: W]),
         .d_i    (InCarry[row_lo(2*k+1, W) +: W]),
         .sum_o  (red_sum  [row_lo(k, W) +: W]),
         .carry_o(red_carry[row_lo(k, W) +: W])
      );
   end

   occ_e              state_q, state_d;
   logic              in_ready_q;
   logic [OW-1:0]     main_sum_q, main_sum_d, main_carry_q, main_carry_d;
   logic [OW-1:0]     skid_sum_q, skid_sum_d, skid_carry_q, skid_carry_d;
   logic [TAG_W-1:0]  main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
   logic              accept, deliver;

   assign accept  = InValid && in_ready_q;
   assign deliver = (state_q != OCC_EMPTY) && OutReady;

   always_comb begin
      state_d      = state_q;
      main_sum_d   = main_sum_q;
      main_carry_d = main_carry_q;
      main_tag_d   = main_tag_q;
      skid_sum_d   = skid_sum_q;
      skid_carry_d = skid_carry_q;
      skid_tag_d   = skid_tag_q;
      if (Flush) begin
         state_d = OCC_EMPTY;
      end else begin
         case (state_q)
            OCC_EMPTY: if (accept) begin
               state_d      = OCC_ONE;
               main_sum_d   = red_sum;
               main_carry_d = red_carry;
               main_tag_d   = InTag;
            end
            OCC_ONE: begin
               if (accept && !deliver) begin
                  state_d      = OCC_TWO;
                  skid_sum_d   = red_sum;
                  skid_carry_d = red_carry;
                  skid_tag_d   = InTag;
               end else if (deliver && !accept) begin
                  state_d = OCC_EMPTY;
               end else if (accept && deliver) begin
                  main_sum_d   = red_sum;
                  main_carry_d = red_carry;
                  main_tag_d   = InTag;
               end
            end
            OCC_TWO: if (deliver) begin
               state_d      = OCC_ONE;
               main_sum_d   = skid_sum_q;
               main_carry_d = skid_carry_q;
               main_tag_d   = skid_tag_q;
            end
            default: state_d = OCC_EMPTY;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q      <= OCC_EMPTY;
         in_ready_q   <= 1'b1;
         main_sum_q   <= '0;
         main_carry_q <= '0;
         main_tag_q   <= '0;
         skid_sum_q   <= '0;
         skid_carry_q <= '0;
         skid_tag_q   <= '0;
      end else begin
         state_q      <= state_d;
         // Ready is precomputed from the next state so it leaves a flop directly.
         in_ready_q   <= (state_d != OCC_TWO);
         main_sum_q   <= main_sum_d;
         main_carry_q <= main_carry_d;
         main_tag_q   <= main_tag_d;
         skid_sum_q   <= skid_sum_d;
         skid_carry_q <= skid_carry_d;
         skid_tag_q   <= skid_tag_d;
      end
   end

   assign InReady  = in_ready_q;
   assign OutValid = (state_q != OCC_EMPTY);
   assign Busy     = OutValid;
   assign OutSum   = main_sum_q;
   assign OutCarry = main_carry_q;
   assign OutTag   = main_tag_q;

endmodule

// File: tb/tb_mul_csa_reduce_stage.sv
// Directed bench for mul_csa_reduce_stage: vector table for the arithmetic,
// hand sequences for backpressure, simultaneous handshake, flush and reset.
module tb_mul_csa_reduce_stage;

   localparam int W       = 128;
   localparam int N_PAIRS = 8;
   localparam int TAG_W   = 3;
   localparam int NK      = N_PAIRS / 2;

   logic                     Clk = 1'b0;
   logic                     Rst = 1'b0;
   logic                     InValid = 1'b0;
   logic                     InReady;
   logic [N_PAIRS*W-1:0]     InSum = '0;
   logic [N_PAIRS*W-1:0]     InCarry = '0;
   logic [TAG_W-1:0]         InTag = '0;
   logic                     Flush = 1'b0;
   logic                     OutValid;
   logic                     OutReady = 1'b0;
   logic [NK*W-1:0]          OutSum;
   logic [NK*W-1:0]          OutCarry;
   logic [TAG_W-1:0]         OutTag;
   logic                     Busy;

   int checks = 0;
   int failures = 0;

   mul_csa_reduce_stage #(.W(W), .N_PAIRS(N_PAIRS), .TAG_W(TAG_W)) dut (
      .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
      .InSum(InSum), .InCarry(InCarry), .InTag(InTag), .Flush(Flush),
      .OutValid(OutValid), .OutReady(OutReady), .OutSum(OutSum),
      .OutCarry(OutCarry), .OutTag(OutTag), .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int                pair;
      logic [W-1:0]      a, b, c, d;
      logic [TAG_W-1:0]  tag;
      logic [W-1:0]      exp;
   } vec_t;

   vec_t vecs[5];

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_pair(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
      InSum   = '0;
      InCarry = '0;
      InSum  [2*p*W     +: W] = a;
      InSum  [(2*p+1)*W +: W] = b;
      InCarry[2*p*W     +: W] = c;
      InCarry[(2*p+1)*W +: W] = d;
   endtask

   // Beat whose pair-0 total is tag*17 + 3.
   task automatic set_beat(input logic [TAG_W-1:0] t);
      logic [W-1:0] tv;
      tv = W'(t);
      set_pair(0, tv, tv << 4, W'(1), W'(2));
      InTag = t;
   endtask

   function automatic logic [W-1:0] row_total(input int k);
      return OutSum[k*W +: W] + OutCarry[k*W +: W];
   endfunction

   function automatic logic [W-1:0] others_total(input int p);
      logic [W-1:0] acc;
      acc = '0;
      for (int k = 0; k < NK; k++)
         if (k != p) acc = acc | row_total(k);
      return acc;
   endfunction

   function automatic logic [W-1:0] beat_total(input int t);
      return W'(t * 17 + 3);
   endfunction

   logic [W-1:0] snap_sum, snap_carry;

   initial begin
      vecs[0] = '{pair: 0, a: W'(1), b: W'(2), c: W'(3), d: W'(4), tag: 3'd5, exp: W'(10)};
      vecs[1] = '{pair: 0, a: {W{1'b1}}, b: {W{1'b1}}, c: {W{1'b1}}, d: {W{1'b1}},
                  tag: 3'd2, exp: {{(W-3){1'b1}}, 3'b100}};
      vecs[2] = '{pair: 3, a: W'('h0F), b: W'('hF0), c: W'('hFF00), d: W'(1),
                  tag: 3'd7, exp: W'('h10000)};
      vecs[3] = '{pair: 1, a: {1'b1, {(W-1){1'b0}}}, b: {1'b1, {(W-1){1'b0}}}, c: W'(5),
                  d: W'(0), tag: 3'd1, exp: W'(5)};
      vecs[4] = '{pair: 2, a: W'('hAAAA), b: W'('h5555), c: W'(1), d: W'(0),
                  tag: 3'd3, exp: W'('h10000)};

      // Reset state
      step(); step();
      chk("rst_outvalid", W'(OutValid), W'(0));
      chk("rst_busy",     W'(Busy),     W'(0));
      chk("rst_inready",  W'(InReady),  W'(1));
      chk("rst_outsum",   OutSum[W-1:0],   '0);
      chk("rst_outcarry", OutCarry[W-1:0], '0);
      chk("rst_outtag",   W'(OutTag),   W'(0));
      Rst = 1'b1;
      step();

      // Single-beat arithmetic vectors, one beat in and out each
      OutReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_pair(vecs[i].pair, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
         InTag   = vecs[i].tag;
         InValid = 1'b1;
         step();
         InValid = 1'b0;
         chk($sformatf("v%0d_outvalid", i), W'(OutValid), W'(1));
         chk($sformatf("v%0d_total", i),    row_total(vecs[i].pair), vecs[i].exp);
         chk($sformatf("v%0d_carry_b0", i), W'(OutCarry[vecs[i].pair*W]), W'(0));
         chk($sformatf("v%0d_others", i),   others_total(vecs[i].pair), '0);
         chk($sformatf("v%0d_tag", i),      W'(OutTag), W'(vecs[i].tag));
         step();
         chk($sformatf("v%0d_drained", i),  W'(OutValid), W'(0));
      end

      // Backpressure: 1 and 2 accepted, 3 held, then ordered drain
      OutReady = 1'b0;
      set_beat(3'd1); InValid = 1'b1;
      step();
      chk("bp_ready_after1", W'(InReady), W'(1));
      set_beat(3'd2);
      step();
      chk("bp_ready_after2", W'(InReady), W'(0));
      set_beat(3'd3);
      step();
      chk("bp_ready_held", W'(InReady), W'(0));
      chk("bp_tag_head",   W'(OutTag),  W'(1));
      snap_sum   = OutSum[W-1:0];
      snap_carry = OutCarry[W-1:0];
      step(); step();
      chk("bp_stable_sum",   OutSum[W-1:0],   snap_sum);
      chk("bp_stable_carry", OutCarry[W-1:0], snap_carry);
      chk("bp_stable_tag",   W'(OutTag),      W'(1));
      chk("bp_total1",       row_total(0),    beat_total(1));
      OutReady = 1'b1;
      step();
      chk("bp_tag2", W'(OutTag), W'(2));
      chk("bp_total2", row_total(0), beat_total(2));
      chk("bp_ready_one", W'(InReady), W'(1));
      // State ONE: beat 3 accepted while beat 2 is delivered
      step();
      InValid = 1'b0;
      chk("sim_valid", W'(OutValid), W'(1));
      chk("sim_tag3",  W'(OutTag),   W'(3));
      chk("sim_total3", row_total(0), beat_total(3));
      step();
      chk("bp_empty", W'(OutValid), W'(0));

      // Flush in state TWO with a beat offered
      OutReady = 1'b0;
      set_beat(3'd4); InValid = 1'b1;
      step();
      set_beat(3'd5);
      step();
      chk("fl_two_ready", W'(InReady), W'(0));
      set_beat(3'd6); Flush = 1'b1;
      step();
      Flush = 1'b0; InValid = 1'b0;
      chk("fl_outvalid", W'(OutValid), W'(0));
      chk("fl_busy",     W'(Busy),     W'(0));
      chk("fl_inready",  W'(InReady),  W'(1));
      OutReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("fl_quiet%0d", i), W'(OutValid), W'(0));
      end

      // Reset while in state TWO
      OutReady = 1'b0;
      set_beat(3'd1); InValid = 1'b1;
      step();
      set_beat(3'd2);
      step();
      InValid = 1'b0;
      chk("rm_two_busy", W'(Busy), W'(1));
      Rst = 1'b0;
      step();
      Rst = 1'b1;
      chk("rm_outvalid", W'(OutValid), W'(0));
      chk("rm_outsum",   OutSum[W-1:0], '0);
      chk("rm_outtag",   W'(OutTag),  W'(0));
      chk("rm_inready",  W'(InReady), W'(1));
      OutReady = 1'b1;
      set_beat(3'd7); InValid = 1'b1;
      step();
      InValid = 1'b0;
      chk("rm_lat_valid", W'(OutValid), W'(1));
      chk("rm_lat_tag",   W'(OutTag),   W'(7));
      chk("rm_lat_total", row_total(0), beat_total(7));
      step();
      chk("rm_drained", W'(OutValid), W'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
